toy_datapath: RTL and testbench
===============================

Name: toy_datapath

Overview:
- Execution datapath for the ToyProcessor. It sits directly downstream of the control sequencer and consumes its one-hot step strobes S0..S5.
- Fetches from an external instruction memory, executes on an 8-bit accumulator and a 4-entry scratch register file, and updates the PC.
- Produces the sticky OVERFLOW flag that feeds back into the sequencer.

Parameters:
DATA_W, 8, accumulator/register/ALU width
ADDR_W, 4, PC and instruction-memory address width; also operand field width

Ports:
CLK  input  1  system clock, rising-edge
RESET  input  1  asynchronous, active-low reset
CLR  input  1  synchronous clear, active-high
S0  input  1  fetch strobe
S1  input  1  decode strobe
S2  input  1  operand-read strobe
S3  input  1  execute strobe
S4  input  1  writeback strobe
S5  input  1  PC-update strobe
IMEM_ADDR  output  ADDR_W  instruction address; combinational copy of PC
IMEM_DATA  input  4+ADDR_W  instruction word: {opcode[3:0], operand[ADDR_W-1:0]}
ACC_OUT  output  DATA_W  accumulator value
PC_OUT  output  ADDR_W  program counter
ZERO  output  1  registered; ACC==0 after last writeback
OVERFLOW  output  1  sticky signed-overflow flag

Behaviour:
- Clock and reset: single clock CLK. RESET is asynchronous, active-low.
- While RESET=0: PC, IR, OPB, RESULT, ACC, R0..R3, ZERO and OVERFLOW are all 0.
- CLR=1 at a rising edge has the same effect as reset and overrides any strobe in that cycle.
- Strobe decoding:
  - Exactly one strobe is expected per cycle.
  - If several are high, only the lowest-index strobe acts.
  - With no strobe high, all state holds.
- Per-strobe actions, each taking effect at the rising edge while the strobe is high:
  - S0: IR <= IMEM_DATA, where IMEM_ADDR = PC.
  - S1: OPB <= zero-extended operand for immediate ops, or R[operand[1:0]] for register ops.
  - S2: OPB <= R[operand[1:0]] again. This re-reads the register so a register written in the previous S4 is visible. Immediate ops hold OPB.
  - S3: RESULT <= ALU(ACC, OPB), DATA_W+1 bits wide. ovf_pending <= signed overflow of ADD/SUB.
  - S4: writeback per opcode. ZERO updates only when ACC is written. OVERFLOW <= OVERFLOW | ovf_pending for ADD/SUB ops.
  - S5: PC <= jump target or PC+1. PC wraps modulo 2^ADDR_W, so 15 -> 0 for ADDR_W=4.
- Opcodes (codes not listed act as NOP, as does 0x0):
  - 0x1 LDI: ACC <= imm.
  - 0x2 ADDI: ACC <= ACC+imm.
  - 0x3 SUBI: ACC <= ACC-imm.
  - 0x4 ST: R[n] <= ACC.
  - 0x5 ADDR: ACC <= ACC+R[n].
  - 0x6 SUBR: ACC <= ACC-R[n].
  - 0x7 JMP: target = operand.
  - 0x8 JZ: target = operand if ZERO, else PC+1.
  - 0x9 CLRV: OVERFLOW <= 0 at S4. A CLRV wins over any pending set in the same S4.
- Arithmetic:
  - Two's complement, result truncated to DATA_W.
  - Signed overflow means the operands have equal signs (ADD) or different signs (SUB) and the result sign differs from ACC's sign.
  - Carry out is ignored.
- OVERFLOW:
  - Sticky: once set, it stays 1 across later instructions.
  - Cleared only by reset, CLR or CLRV.
- Reset mid-instruction: all partial state is discarded. Execution restarts at PC=0 on the next S0.
- IMEM_ADDR changes only at S5 edges, reset and CLR.

Test Plan:
- Reset: hold RESET=0 with strobes toggling -> ACC_OUT=0, PC_OUT=0, OVERFLOW=0, IMEM_ADDR=0. Releasing RESET mid-S3 -> no state change until the next strobe.
- Program LDI 5; ADDI 3; ST R1; ADDR R1, each run through a full S0..S5 cycle -> ACC=8 after instr 1, R1=8, ACC=16 (0x10) after instr 3, ZERO=0, PC_OUT=4.
- Overflow: LDI 0x0F, then ADDR R1 with R1=0x7F -> ACC=0x8E, OVERFLOW=1. It stays 1 through a following LDI 1. CLRV -> OVERFLOW=0 after its S4.
- Branch: LDI 0; SUBI 0 -> ZERO=1. JZ 0xA -> PC_OUT=0xA. With ZERO=0, JZ -> PC_OUT=PC+1. JMP at PC=15 with operand 2 -> PC_OUT=2. NOP at PC=15 -> PC_OUT=0.
- CLR pulsed high for 1 cycle with OVERFLOW=1, ACC=0x8E and S4 asserted -> all state 0 the next cycle, and that S4 writeback is suppressed.
- S3 and S5 asserted together -> only the execute action occurs and PC holds. No strobes for 5 cycles -> ACC, PC and flags unchanged.

Source files
------------

// File: rtl/toy_datapath.sv
// Execution datapath for the ToyProcessor: strobe-driven fetch/decode/execute/writeback/PC-update
// on an 8-bit accumulator, a 4-entry scratch register file and a sticky signed-overflow flag.
module toy_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CLR,
    input  logic                S0,
    input  logic                S1,
    input  logic                S2,
    input  logic                S3,
    input  logic                S4,
    input  logic                S5,
    output logic [ADDR_W-1:0]   IMEM_ADDR,
    input  logic [ADDR_W+3:0]   IMEM_DATA,
    output logic [DATA_W-1:0]   ACC_OUT,
    output logic [ADDR_W-1:0]   PC_OUT,
    output logic                ZERO,
    output logic                OVERFLOW
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_SUBI = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_ADDR = 4'h5;
    localparam logic [3:0] OP_SUBR = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_CLRV = 4'h9;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    // Architectural and pipeline-step state
    logic [ADDR_W-1:0] pc_q,       pc_d;
    logic [ADDR_W+3:0] ir_q,       ir_d;
    logic [DATA_W-1:0] opb_q,      opb_d;
    logic [DATA_W:0]   result_q,   result_d;
    logic [DATA_W-1:0] acc_q,      acc_d;
    logic [DATA_W-1:0] rf_q [0:3];
    logic [DATA_W-1:0] rf_d [0:3];
    logic              zero_q,     zero_d;
    logic              ovf_q,      ovf_d;
    logic              ovf_pend_q, ovf_pend_d;

    // Lowest-index strobe wins when more than one is high.
    logic [5:0] step;

    always_comb begin
        step = 6'b000000;
        if (S0)      step[0] = 1'b1;
        else if (S1) step[1] = 1'b1;
        else if (S2) step[2] = 1'b1;
        else if (S3) step[3] = 1'b1;
        else if (S4) step[4] = 1'b1;
        else if (S5) step[5] = 1'b1;
    end

    // Instruction field decode
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [1:0]        rf_idx;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rf_rd;
    logic              is_reg_op;
    logic              is_add;
    logic              is_sub;
    logic              writes_acc;

    assign opcode     = ir_q[ADDR_W+3:ADDR_W];
    assign operand    = ir_q[ADDR_W-1:0];
    assign rf_idx     = operand[1:0];
    assign imm_ext    = {{(DATA_W-ADDR_W){1'b0}}, operand};
    assign rf_rd      = rf_q[rf_idx];
    assign is_reg_op  = (opcode == OP_ADDR) || (opcode == OP_SUBR);
    assign is_add     = (opcode == OP_ADDI) || (opcode == OP_ADDR);
    assign is_sub     = (opcode == OP_SUBI) || (opcode == OP_SUBR);
    assign writes_acc = (opcode == OP_LDI) || is_add || is_sub;

    // ALU: result is one bit wider than the accumulator; the extra bit is the carry/borrow.
    logic [DATA_W:0] alu_res;
    logic            alu_ovf;

    always_comb begin
        alu_res = {1'b0, acc_q};
        alu_ovf = 1'b0;
        if (opcode == OP_LDI) begin
            alu_res = {1'b0, opb_q};
        end else if (is_add) begin
            alu_res = {1'b0, acc_q} + {1'b0, opb_q};
            alu_ovf = (acc_q[DATA_W-1] == opb_q[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
        end else if (is_sub) begin
            alu_res = {1'b0, acc_q} - {1'b0, opb_q};
            alu_ovf = (acc_q[DATA_W-1] != opb_q[DATA_W-1]) &&
                      (alu_res[DATA_W-1] != acc_q[DATA_W-1]);
        end
    end

    // Carry out of the ALU is carried in RESULT but never consumed.
    logic unused_carry;
    assign unused_carry = result_q[DATA_W];

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        opb_d      = opb_q;
        result_d   = result_q;
        acc_d      = acc_q;
        rf_d       = rf_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        ovf_pend_d = ovf_pend_q;

        if (step[0]) begin
            ir_d = IMEM_DATA;
        end

        if (step[1]) begin
            opb_d = is_reg_op ? rf_rd : imm_ext;
        end

        if (step[2] && is_reg_op) begin
            opb_d = rf_rd;
        end

        if (step[3]) begin
            result_d   = alu_res;
            ovf_pend_d = alu_ovf;
        end

        if (step[4]) begin
            if (writes_acc) begin
                acc_d  = result_q[DATA_W-1:0];
                zero_d = (result_q[DATA_W-1:0] == '0);
            end
            if (opcode == OP_ST) begin
                rf_d[rf_idx] = acc_q;
            end
            if (is_add || is_sub) begin
                ovf_d = ovf_q | ovf_pend_q;
            end
            if (opcode == OP_CLRV) begin
                ovf_d = 1'b0;
            end
        end

        if (step[5]) begin
            if (opcode == OP_JMP)
                pc_d = operand;
            else if (opcode == OP_JZ && zero_q)
                pc_d = operand;
            else
                pc_d = pc_q + PC_ONE;
        end

        // Synchronous clear discards everything, including any strobe action this cycle.
        if (CLR) begin
            pc_d       = '0;
            ir_d       = '0;
            opb_d      = '0;
            result_d   = '0;
            acc_d      = '0;
            zero_d     = 1'b0;
            ovf_d      = 1'b0;
            ovf_pend_d = 1'b0;
            for (int i = 0; i < 4; i++) rf_d[i] = '0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q       <= '0;
            ir_q       <= '0;
            opb_q      <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            opb_q      <= opb_d;
            result_q   <= result_d;
            acc_q      <= acc_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            ovf_pend_q <= ovf_pend_d;
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign IMEM_ADDR = pc_q;
    assign PC_OUT    = pc_q;
    assign ACC_OUT   = acc_q;
    assign ZERO      = zero_q;
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_toy_datapath.sv
// Testbench for toy_datapath: instruction-level reference model feeding an expected queue,
// plus directed scenarios for reset, overflow, branching, CLR and strobe priority.
module tb_toy_datapath;

    logic       CLK;
    logic       RESET;
    logic       CLR;
    logic       S0, S1, S2, S3, S4, S5;
    logic [3:0] IMEM_ADDR;
    logic [7:0] IMEM_DATA;
    logic [7:0] ACC_OUT;
    logic [3:0] PC_OUT;
    logic       ZERO;
    logic       OVERFLOW;

    toy_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .CLR       (CLR),
        .S0        (S0),
        .S1        (S1),
        .S2        (S2),
        .S3        (S3),
        .S4        (S4),
        .S5        (S5),
        .IMEM_ADDR (IMEM_ADDR),
        .IMEM_DATA (IMEM_DATA),
        .ACC_OUT   (ACC_OUT),
        .PC_OUT    (PC_OUT),
        .ZERO      (ZERO),
        .OVERFLOW  (OVERFLOW)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: {OVERFLOW, ZERO, PC, ACC} after each full instruction
    logic [13:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_acc;
    logic [7:0] m_r [0:3];
    logic       m_zero;
    logic       m_ovf;
    logic [3:0] m_pc;

    task automatic model_reset();
        m_acc  = 8'h00;
        m_zero = 1'b0;
        m_ovf  = 1'b0;
        m_pc   = 4'h0;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    endtask

    task automatic model_instr(input logic [3:0] op, input logic [3:0] opnd);
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] nxt;
        nxt = m_pc + 4'd1;
        b   = (op == 4'h5 || op == 4'h6) ? m_r[opnd[1:0]] : {4'h0, opnd};
        case (op)
            4'h1: begin
                m_acc  = b;
                m_zero = (m_acc == 8'h00);
            end
            4'h2, 4'h5: begin
                r = m_acc + b;
                if (m_acc[7] == b[7] && r[7] != m_acc[7]) m_ovf = 1'b1;
                m_acc  = r;
                m_zero = (m_acc == 8'h00);
            end
            4'h3, 4'h6: begin
                r = m_acc - b;
                if (m_acc[7] != b[7] && r[7] != m_acc[7]) m_ovf = 1'b1;
                m_acc  = r;
                m_zero = (m_acc == 8'h00);
            end
            4'h4: m_r[opnd[1:0]] = m_acc;
            4'h7: nxt = opnd;
            4'h8: if (m_zero) nxt = opnd;
            4'h9: m_ovf = 1'b0;
            default: ;
        endcase
        m_pc = nxt;
        exp_q.push_back({m_ovf, m_zero, m_pc, m_acc});
    endtask

    // Driver tasks
    task automatic pulse(input logic [5:0] s);
        {S5, S4, S3, S2, S1, S0} = s;
        @(posedge CLK);
        #1;
        {S5, S4, S3, S2, S1, S0} = 6'b000000;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] opnd);
        logic [13:0] exp_v;
        logic [13:0] got_v;
        IMEM_DATA = {op, opnd};
        checks++;
        if (IMEM_ADDR !== m_pc) begin
            errors++;
            $display("FAIL imem_addr: got %h expected %h", IMEM_ADDR, m_pc);
        end
        model_instr(op, opnd);
        for (int i = 0; i < 6; i++) pulse(6'b000001 << i);
        got_v = {OVERFLOW, ZERO, PC_OUT, ACC_OUT};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h expected an entry", got_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL instr op=%h opnd=%h {ovf,zero,pc,acc}: got %h expected %h",
                         op, opnd, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        CLR   = 1'b0;
        IMEM_DATA = 8'h15;
        {S5, S4, S3, S2, S1, S0} = 6'b000000;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 6; i++) pulse(6'b000001 << i);
        checks++; if (ACC_OUT !== 8'h00)  begin errors++; $display("FAIL reset_acc: got %h expected 00", ACC_OUT); end
        checks++; if (PC_OUT !== 4'h0)    begin errors++; $display("FAIL reset_pc: got %h expected 0", PC_OUT); end
        checks++; if (OVERFLOW !== 1'b0)  begin errors++; $display("FAIL reset_ovf: got %b expected 0", OVERFLOW); end
        checks++; if (IMEM_ADDR !== 4'h0) begin errors++; $display("FAIL reset_imem_addr: got %h expected 0", IMEM_ADDR); end
        checks++; if (ZERO !== 1'b0)      begin errors++; $display("FAIL reset_zero: got %b expected 0", ZERO); end
        // Release reset while S3 is held
        S3 = 1'b1;
        #2;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        S3 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({OVERFLOW, ZERO, PC_OUT, ACC_OUT} !== 14'h0) begin
            errors++;
            $display("FAIL reset_release_s3: got %h expected 0000", {OVERFLOW, ZERO, PC_OUT, ACC_OUT});
        end
        model_reset();
    endtask

    task automatic test_program();
        run_instr(4'h1, 4'd5);
        run_instr(4'h2, 4'd3);
        checks++; if (ACC_OUT !== 8'h08) begin errors++; $display("FAIL prog_acc8: got %h expected 08", ACC_OUT); end
        run_instr(4'h4, 4'd1);
        run_instr(4'h5, 4'd1);
        checks++; if (ACC_OUT !== 8'h10) begin errors++; $display("FAIL prog_acc16: got %h expected 10", ACC_OUT); end
        checks++; if (ZERO !== 1'b0)     begin errors++; $display("FAIL prog_zero: got %b expected 0", ZERO); end
        checks++; if (PC_OUT !== 4'h4)   begin errors++; $display("FAIL prog_pc: got %h expected 4", PC_OUT); end
    endtask

    task automatic test_overflow();
        // Build 0x7F in R1 from 4-bit immediates
        run_instr(4'h1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            run_instr(4'h4, 4'd0);
            run_instr(4'h5, 4'd0);
        end
        run_instr(4'h2, 4'd7);
        checks++; if (ACC_OUT !== 8'h7F) begin errors++; $display("FAIL ovf_build: got %h expected 7f", ACC_OUT); end
        run_instr(4'h4, 4'd1);
        run_instr(4'h1, 4'hF);
        run_instr(4'h5, 4'd1);
        checks++; if (ACC_OUT !== 8'h8E) begin errors++; $display("FAIL ovf_acc: got %h expected 8e", ACC_OUT); end
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", OVERFLOW); end
        run_instr(4'h1, 4'd1);
        checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", OVERFLOW); end
        run_instr(4'h9, 4'd0);
        checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clrv: got %b expected 0", OVERFLOW); end
    endtask

    task automatic test_branch();
        run_instr(4'h1, 4'd0);
        run_instr(4'h3, 4'd0);
        checks++; if (ZERO !== 1'b1)   begin errors++; $display("FAIL br_zero: got %b expected 1", ZERO); end
        run_instr(4'h8, 4'hA);
        checks++; if (PC_OUT !== 4'hA) begin errors++; $display("FAIL br_jz_taken: got %h expected a", PC_OUT); end
        run_instr(4'h1, 4'd1);
        run_instr(4'h8, 4'd3);
        checks++; if (PC_OUT !== 4'hC) begin errors++; $display("FAIL br_jz_not_taken: got %h expected c", PC_OUT); end
        for (int i = 0; i < 3; i++) run_instr(4'h0, 4'd0);
        checks++; if (PC_OUT !== 4'hF) begin errors++; $display("FAIL br_pc15: got %h expected f", PC_OUT); end
        run_instr(4'h7, 4'd2);
        checks++; if (PC_OUT !== 4'h2) begin errors++; $display("FAIL br_jmp_from15: got %h expected 2", PC_OUT); end
        run_instr(4'h7, 4'hF);
        run_instr(4'h0, 4'd0);
        checks++; if (PC_OUT !== 4'h0) begin errors++; $display("FAIL br_wrap: got %h expected 0", PC_OUT); end
    endtask

    task automatic test_clr();
        run_instr(4'h1, 4'hF);
        run_instr(4'h5, 4'd1);
        checks++;
        if (ACC_OUT !== 8'h8E || OVERFLOW !== 1'b1) begin
            errors++;
            $display("FAIL clr_setup: got acc=%h ovf=%b expected acc=8e ovf=1", ACC_OUT, OVERFLOW);
        end
        IMEM_DATA = {4'h2, 4'd1};
        for (int i = 0; i < 4; i++) pulse(6'b000001 << i);
        CLR = 1'b1;
        pulse(6'b010000);
        CLR = 1'b0;
        checks++;
        if ({OVERFLOW, ZERO, PC_OUT, ACC_OUT} !== 14'h0) begin
            errors++;
            $display("FAIL clr_state: got %h expected 0000", {OVERFLOW, ZERO, PC_OUT, ACC_OUT});
        end
        model_reset();
        // Register file must also be cleared
        run_instr(4'h1, 4'd3);
        run_instr(4'h5, 4'd1);
        checks++; if (ACC_OUT !== 8'h03) begin errors++; $display("FAIL clr_rf: got %h expected 03", ACC_OUT); end
    endtask

    task automatic test_multi_strobe();
        logic [3:0] pc0;
        logic [7:0] acc0;
        pc0  = m_pc;
        acc0 = m_acc;
        IMEM_DATA = {4'h1, 4'd7};
        pulse(6'b000001);
        pulse(6'b000010);
        pulse(6'b000100);
        pulse(6'b101000);
        checks++; if (PC_OUT !== pc0)   begin errors++; $display("FAIL multi_pc_hold: got %h expected %h", PC_OUT, pc0); end
        checks++; if (ACC_OUT !== acc0) begin errors++; $display("FAIL multi_acc_hold: got %h expected %h", ACC_OUT, acc0); end
        pulse(6'b010000);
        checks++; if (ACC_OUT !== 8'h07) begin errors++; $display("FAIL multi_exec: got %h expected 07", ACC_OUT); end
        pulse(6'b100000);
        m_acc  = 8'h07;
        m_zero = 1'b0;
        m_pc   = pc0 + 4'd1;
        checks++; if (PC_OUT !== m_pc)  begin errors++; $display("FAIL multi_pc_step: got %h expected %h", PC_OUT, m_pc); end
        // Idle: nothing may move
        for (int i = 0; i < 5; i++) begin
            IMEM_DATA = 8'($urandom_range(0, 255));
            @(posedge CLK);
            #1;
        end
        checks++;
        if ({OVERFLOW, ZERO, PC_OUT, ACC_OUT} !== {m_ovf, m_zero, m_pc, m_acc}) begin
            errors++;
            $display("FAIL idle_hold: got %h expected %h",
                     {OVERFLOW, ZERO, PC_OUT, ACC_OUT}, {m_ovf, m_zero, m_pc, m_acc});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_program();
        test_overflow();
        test_branch();
        test_clr();
        test_multi_strobe();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
